// File: rtl/rv_isa_pkg.sv
// RV32I decode definitions: opcodes, ALU op codes, control-flag bundle
// and the funct3 -> ALU op helper shared by the decode stage.
package rv_isa_pkg;

  localparam int REG_W = 5;
  localparam int F3_W  = 3;
  localparam int ALU_W = 8;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [ALU_W-1:0] ALU_NOP  = 8'h00;
  localparam logic [ALU_W-1:0] ALU_ADD  = 8'h01;
  localparam logic [ALU_W-1:0] ALU_SUB  = 8'h02;
  localparam logic [ALU_W-1:0] ALU_SLL  = 8'h03;
  localparam logic [ALU_W-1:0] ALU_SLT  = 8'h04;
  localparam logic [ALU_W-1:0] ALU_SLTU = 8'h05;
  localparam logic [ALU_W-1:0] ALU_XOR  = 8'h06;
  localparam logic [ALU_W-1:0] ALU_SRL  = 8'h07;
  localparam logic [ALU_W-1:0] ALU_SRA  = 8'h08;
  localparam logic [ALU_W-1:0] ALU_OR   = 8'h09;
  localparam logic [ALU_W-1:0] ALU_AND  = 8'h0a;
  localparam logic [ALU_W-1:0] ALU_PASS = 8'h0b;
  // M ops occupy 0x10..0x17 in funct3 order (mul, mulh, ..., remu)
  localparam logic [ALU_W-1:0] ALU_MUL  = 8'h10;

  typedef struct packed {
    logic re1;
    logic re2;
    logic we;
    logic pce;
    logic imme;
    logic jmpe;
    logic bre;
    logic mrd;
    logic mwr;
    logic illegal;
  } dec_ctrl_t;

  // funct3 to ALU op; alt selects sub/sra (funct7[5])
  function automatic logic [ALU_W-1:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv_decode_stage_if.sv
// Fetch-side and downstream-side signals of the decode stage.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the source keeps valid and data stable until that edge, and
// in_ready does not depend on in_valid.
interface rv_decode_stage_if #(
  parameter int XLEN = 32,
  parameter int OP_W = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_prog;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      ra1, ra2, wa;
  logic [XLEN-1:0] imm;
  logic [OP_W-1:0] op;
  logic [2:0]      funct3;
  logic            re1, re2, we, pce, imme, jmpe, bre, mrd, mwr, illegal;

  // environment side: fetch plus downstream consumer
  modport master (
    output in_valid, in_prog, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, ra1, ra2, wa, imm, op, funct3,
    input  re1, re2, we, pce, imme, jmpe, bre, mrd, mwr, illegal
  );

  // decode stage side
  modport slave (
    input  in_valid, in_prog, in_pc, out_ready,
    output in_ready, out_valid, out_pc, ra1, ra2, wa, imm, op, funct3,
    output re1, re2, we, pce, imme, jmpe, bre, mrd, mwr, illegal
  );
endinterface

// File: rtl/rv_decode_comb.sv
// Pure combinational RV32I instruction decoder.
// Optional macro RV_M_EXT_EN: decode mul..remu as ALU ops 0x10..0x17;
// without it those encodings are illegal.
module rv_decode_comb
  import rv_isa_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OP_W = 8
) (
  input  logic [31:0]     prog,
  output logic [4:0]      ra1,
  output logic [4:0]      ra2,
  output logic [4:0]      wa,
  output logic [XLEN-1:0] imm,
  output logic [OP_W-1:0] op,
  output logic [2:0]      funct3,
  output dec_ctrl_t       ctrl
);

  logic [6:0]       opc;
  logic [4:0]       rd, rs1, rs2;
  logic [2:0]       f3;
  logic [6:0]       f7;
  dec_ctrl_t        c;
  logic [ALU_W-1:0] aop;
  logic [31:0]      imm32;
  logic             ill;

  assign opc = prog[6:0];
  assign rd  = prog[11:7];
  assign f3  = prog[14:12];
  assign rs1 = prog[19:15];
  assign rs2 = prog[24:20];
  assign f7  = prog[31:25];

  // decode by opcode, then squash everything for illegal and rd==x0 writes
  always_comb begin
    c     = '0;
    aop   = ALU_NOP;
    imm32 = '0;
    ill   = 1'b0;
    case (opc)
      OPC_LUI: begin
        aop = ALU_PASS; c.imme = 1'b1; c.we = 1'b1;
        imm32 = {prog[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        aop = ALU_ADD; c.pce = 1'b1; c.imme = 1'b1; c.we = 1'b1;
        imm32 = {prog[31:12], 12'b0};
      end
      OPC_JAL: begin
        aop = ALU_ADD; c.pce = 1'b1; c.imme = 1'b1; c.jmpe = 1'b1; c.we = 1'b1;
        imm32 = {{12{prog[31]}}, prog[19:12], prog[20], prog[30:21], 1'b0};
      end
      OPC_JALR: begin
        aop = ALU_ADD; c.re1 = 1'b1; c.imme = 1'b1; c.jmpe = 1'b1; c.we = 1'b1;
        imm32 = {{20{prog[31]}}, prog[31:20]};
      end
      OPC_BRANCH: begin
        if (f3 == 3'b010 || f3 == 3'b011) ill = 1'b1;
        aop = ALU_SUB; c.bre = 1'b1; c.re1 = 1'b1; c.re2 = 1'b1;
        imm32 = {{20{prog[31]}}, prog[7], prog[30:25], prog[11:8], 1'b0};
      end
      OPC_LOAD: begin
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) ill = 1'b1;
        aop = ALU_ADD; c.mrd = 1'b1; c.re1 = 1'b1; c.imme = 1'b1; c.we = 1'b1;
        imm32 = {{20{prog[31]}}, prog[31:20]};
      end
      OPC_STORE: begin
        if (f3 > 3'b010) ill = 1'b1;
        aop = ALU_ADD; c.mwr = 1'b1; c.re1 = 1'b1; c.re2 = 1'b1; c.imme = 1'b1;
        imm32 = {{20{prog[31]}}, prog[31:25], prog[11:7]};
      end
      OPC_OPIMM: begin
        c.re1 = 1'b1; c.imme = 1'b1; c.we = 1'b1;
        imm32 = {{20{prog[31]}}, prog[31:20]};
        if (f3 == 3'b001) begin
          if (f7 != 7'b0000000) ill = 1'b1;
          aop = ALU_SLL; imm32 = {27'b0, rs2};
        end else if (f3 == 3'b101) begin
          if (f7 == 7'b0000000)      aop = ALU_SRL;
          else if (f7 == 7'b0100000) aop = ALU_SRA;
          else                       ill = 1'b1;
          imm32 = {27'b0, rs2};
        end else begin
          aop = alu_from_f3(f3, 1'b0);
        end
      end
      OPC_OP: begin
        c.re1 = 1'b1; c.re2 = 1'b1; c.we = 1'b1;
        if (f7 == 7'b0000000) begin
          aop = alu_from_f3(f3, 1'b0);
        end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
          aop = alu_from_f3(f3, 1'b1);
        end else if (f7 == 7'b0000001) begin
`ifdef RV_M_EXT_EN
          aop = ALU_MUL + {5'b0, f3};
`else
          ill = 1'b1;
`endif
        end else begin
          ill = 1'b1;
        end
      end
      OPC_MISC_MEM, OPC_SYSTEM: begin
        // fence/ecall/ebreak: nop bundle
        aop = ALU_NOP;
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      c         = '0;
      c.illegal = 1'b1;
      aop       = ALU_NOP;
      imm32     = '0;
    end else if (rd == 5'd0) begin
      c.we = 1'b0;
    end
  end

  assign ctrl   = c;
  assign op     = OP_W'(aop);
  assign imm    = XLEN'($signed(imm32));
  assign ra1    = c.re1 ? rs1 : 5'd0;
  assign ra2    = c.re2 ? rs2 : 5'd0;
  assign wa     = c.we  ? rd  : 5'd0;
  assign funct3 = c.illegal ? 3'b000 : f3;

endmodule

// File: rtl/rv_decode_stage.sv
// Registered RV32I decode stage: output register plus one skid entry
// around rv_decode_comb, giving full throughput and 1-cycle latency.
// Optional macro RV_M_EXT_EN (see rv_decode_comb) enables M-extension ops.
module rv_decode_stage
  import rv_isa_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OP_W = 8
) (
  input logic               clk,
  input logic               rst,
  input logic               flush,
  rv_decode_stage_if.slave  bus
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [OP_W-1:0] op;
    logic [4:0]      ra1;
    logic [4:0]      ra2;
    logic [4:0]      wa;
    logic [2:0]      funct3;
    dec_ctrl_t       ctrl;
  } bundle_t;

  bundle_t dec, out_q, skid_q;
  logic    out_v, skid_v;
  logic    accept, out_free;

  rv_decode_comb #(.XLEN(XLEN), .OP_W(OP_W)) u_comb (
    .prog   (bus.in_prog),
    .ra1    (dec.ra1),
    .ra2    (dec.ra2),
    .wa     (dec.wa),
    .imm    (dec.imm),
    .op     (dec.op),
    .funct3 (dec.funct3),
    .ctrl   (dec.ctrl)
  );
  assign dec.pc = bus.in_pc;

  assign bus.in_ready = ~skid_v;
  assign accept       = bus.in_valid & ~skid_v;
  assign out_free     = ~out_v | bus.out_ready;

  // output register and skid entry; skid only fills while the output is held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      out_q  <= '0;
      skid_q <= '0;
    end else if (flush) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (out_free) begin
      if (skid_v) begin
        out_q  <= skid_q;
        out_v  <= 1'b1;
        skid_v <= 1'b0;
      end else if (accept) begin
        out_q <= dec;
        out_v <= 1'b1;
      end else begin
        out_v <= 1'b0;
      end
    end else if (accept) begin
      skid_q <= dec;
      skid_v <= 1'b1;
    end
  end

  assign bus.out_valid = out_v;
  assign bus.out_pc    = out_q.pc;
  assign bus.imm       = out_q.imm;
  assign bus.op        = out_q.op;
  assign bus.ra1       = out_q.ra1;
  assign bus.ra2       = out_q.ra2;
  assign bus.wa        = out_q.wa;
  assign bus.funct3    = out_q.funct3;
  assign bus.re1       = out_q.ctrl.re1;
  assign bus.re2       = out_q.ctrl.re2;
  assign bus.we        = out_q.ctrl.we;
  assign bus.pce       = out_q.ctrl.pce;
  assign bus.imme      = out_q.ctrl.imme;
  assign bus.jmpe      = out_q.ctrl.jmpe;
  assign bus.bre       = out_q.ctrl.bre;
  assign bus.mrd       = out_q.ctrl.mrd;
  assign bus.mwr       = out_q.ctrl.mwr;
  assign bus.illegal   = out_q.ctrl.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: decode vectors, backpressure/skid,
// flush and asynchronous reset.
module tb_rv_decode_stage;

  logic clk;
  logic rst;
  logic flush;
  int   n_checks;
  int   n_errors;

  rv_decode_stage_if #(.XLEN(32), .OP_W(8)) bus ();

  rv_decode_stage #(.XLEN(32), .OP_W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  // clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // drive one instruction for one edge with out_ready=1, then sample
  task automatic issue(input logic [31:0] prog, input logic [31:0] pc);
    bus.in_valid  = 1'b1;
    bus.in_prog   = prog;
    bus.in_pc     = pc;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_prog = 32'h0;
    bus.in_pc = 32'h0;
    bus.out_ready = 1'b0;
    #12;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_op", bus.op, 0);
    check("rst_imm", bus.imm, 0);
    check("rst_we", bus.we, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // addi x1,x0,5
    issue(32'h00500093, 32'h0000_1000);
    check("addi_valid", bus.out_valid, 1);
    check("addi_op", bus.op, 32'h01);
    check("addi_wa", bus.wa, 1);
    check("addi_ra1", bus.ra1, 0);
    check("addi_imm", bus.imm, 5);
    check("addi_we", bus.we, 1);
    check("addi_imme", bus.imme, 1);
    check("addi_pc", bus.out_pc, 32'h0000_1000);

    // sub x3,x1,x2
    issue(32'h402081B3, 32'h0000_1004);
    check("sub_op", bus.op, 32'h02);
    check("sub_ra1", bus.ra1, 1);
    check("sub_ra2", bus.ra2, 2);
    check("sub_wa", bus.wa, 3);
    check("sub_en", {bus.re1, bus.re2, bus.we, bus.imme}, 4'b1110);
    check("sub_imm", bus.imm, 0);

    // jal x1,+8
    issue(32'h008000EF, 32'h0000_1008);
    check("jal_imm", bus.imm, 8);
    check("jal_flags", {bus.pce, bus.imme, bus.jmpe, bus.bre}, 4'b1110);
    check("jal_op", bus.op, 32'h01);
    check("jal_wa", bus.wa, 1);

    // sw x5,12(x2)
    issue(32'h00512623, 32'h0000_100C);
    check("sw_imm", bus.imm, 12);
    check("sw_mwr_we", {bus.mwr, bus.we, bus.mrd}, 3'b100);
    check("sw_ra1", bus.ra1, 2);
    check("sw_ra2", bus.ra2, 5);
    check("sw_funct3", bus.funct3, 3'b010);

    // beq x1,x2,-4
    issue(32'hFE208EE3, 32'h0000_1010);
    check("beq_imm", bus.imm, 32'hFFFF_FFFC);
    check("beq_flags", {bus.bre, bus.re1, bus.re2, bus.we, bus.jmpe}, 5'b11100);
    check("beq_op", bus.op, 32'h02);

    // lui x5,0x12345
    issue(32'h123452B7, 32'h0000_1014);
    check("lui_op", bus.op, 32'h0b);
    check("lui_imm", bus.imm, 32'h1234_5000);
    check("lui_regs", {bus.wa, bus.ra1, bus.re1, bus.imme}, {5'd5, 5'd0, 1'b0, 1'b1});

    // addi x0,x0,0: rd==x0 suppresses the write
    issue(32'h00000013, 32'h0000_1018);
    check("nop_we", {bus.we, bus.wa}, 6'd0);
    check("nop_illegal", bus.illegal, 0);

    // all-ones word is illegal
    issue(32'hFFFFFFFF, 32'h0000_101C);
    check("ill_flag", bus.illegal, 1);
    check("ill_we", bus.we, 0);
    check("ill_op_imm", {bus.op, bus.imm}, 40'd0);
    check("ill_valid", bus.out_valid, 1);

    // lw with funct3=011 is illegal
    issue(32'h0000B083, 32'h0000_1020);
    check("ld_f3_ill", bus.illegal, 1);
    check("ld_f3_mrd", bus.mrd, 0);

    // mul x3,x1,x2
    issue(32'h022081B3, 32'h0000_1024);
`ifdef RV_M_EXT_EN
    check("mul_op", bus.op, 32'h10);
    check("mul_illegal", bus.illegal, 0);
`else
    check("mul_op", bus.op, 32'h00);
    check("mul_illegal", bus.illegal, 1);
`endif

    // drain
    tick();
    check("drain_valid", bus.out_valid, 0);

    // backpressure: three back-to-back offers with out_ready=0
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_prog = 32'h00500093; bus.in_pc = 32'h100;
    tick();
    check("bp_rdy_a", bus.in_ready, 1);
    bus.in_prog = 32'h402081B3; bus.in_pc = 32'h104;
    tick();
    check("bp_rdy_b", bus.in_ready, 0);
    bus.in_prog = 32'h008000EF; bus.in_pc = 32'h108;
    tick();
    check("bp_hold_pc", bus.out_pc, 32'h100);
    check("bp_hold_op", bus.op, 32'h01);
    check("bp_rdy_c", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    tick();
    check("bp_out_b", bus.out_pc, 32'h104);
    check("bp_out_b_op", bus.op, 32'h02);
    check("bp_rdy_rel", bus.in_ready, 1);
    tick();
    check("bp_out_c", bus.out_pc, 32'h108);
    check("bp_out_c_jmp", bus.jmpe, 1);
    bus.in_valid = 1'b0;
    tick();
    check("bp_empty", bus.out_valid, 0);

    // flush with skid full
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_prog = 32'h00500093; bus.in_pc = 32'h200;
    tick();
    bus.in_pc = 32'h204;
    tick();
    check("fl_full", bus.in_ready, 0);
    flush = 1'b1;
    tick();
    check("fl_valid", bus.out_valid, 0);
    check("fl_ready", bus.in_ready, 1);
    // input accepted in a flush cycle is discarded
    bus.in_pc = 32'h208;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("fl_discard", bus.out_valid, 0);

    // asynchronous reset mid-transfer
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_pc = 32'h300;
    tick();
    tick();
    check("ar_full", bus.in_ready, 0);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", bus.out_valid, 0);
    check("ar_ready", bus.in_ready, 1);
    check("ar_imm", bus.imm, 0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
